alu_control_muldiv: RTL
=======================

Name: alu_control_muldiv

Overview:
- Parametrised successor to the single-cycle ALU control decoder for the MIPS datapath.
- Decodes ALUop/funct into a 4-bit ALUOperation and computes single-cycle results combinationally.
- Adds iterative signed/unsigned multiply and divide with HI/LO registers, mfhi/mflo, and a busy/stall/done handshake towards the control unit.

Parameters:
- WIDTH, 32, operand/result width; even, >= 4; iteration counter width is derived as clog2(WIDTH)+1.
- MULDIV_EN, 1, 1 = mult/div/mfhi/mflo decoded; 0 = those functs flagged illegal.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  instruction valid this cycle
- ALUop  in  2  00 add, 01 sub, 10 R-type (use funct), 11 slt
- funct  in  6  R-type function field
- A  in  WIDTH  operand rs
- B  in  WIDTH  operand rt
- ALUOperation  out  4  decoded class: 0010 add, 0110 sub, 0000 and, 0001 or, 0011 xor, 1100 nor, 0111 slt, 1111 sltu, 1000 muldiv/move, 1110 illegal
- result  out  WIDTH  combinational result
- zero  out  1  result == 0
- overflow  out  1  signed overflow, funct add/sub only
- illegal  out  1  unrecognised funct with ALUop=10
- stall  out  1  hold the pipeline this cycle
- busy  out  1  mult/div in progress
- done  out  1  one-cycle pulse, HI/LO updated
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Asserting reset mid-operation aborts it; no HI/LO write occurs.
- Combinational decode: funct 100000/100001 add/addu, 100010/100011 sub/subu, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt, 101011 sltu.
- Combinational decode (MULDIV_EN=1 only): 011000 mult, 011001 multu, 011010 div, 011011 divu, 010000 mfhi, 010010 mflo.
- Any other funct with ALUop=10: illegal=1, result=0, ALUOperation=1110.
- Arithmetic: add/sub wrap modulo 2^WIDTH. overflow=1 only for funct 100000/100010 when the signed operation overflows; 0 otherwise, including ALUop 00/01.
- slt/sltu results: 1 or 0, zero-extended to WIDTH.
- mfhi/mflo: result=hi/lo. For mult/div functs, result=0.
- Outputs are valid whether or not start=1; start only qualifies sequential actions.
- FSM states: IDLE, RUN, FIX.
- IDLE: when start=1 and the op is mult/div, on the clock edge latch operand magnitudes (signed ops) or raw values (unsigned ops), latch result signs, load counter=WIDTH, busy<=1, go to RUN.
- RUN: one shift-add multiply step or one restoring-divide step per cycle. Decrement the counter; at counter==1 go to FIX.
- FIX: apply signs. Quotient sign = sign(A) xor sign(B); remainder sign = sign(A); product is negated to 2*WIDTH bits when signs differ. On the edge: write hi/lo, done<=1, busy<=0, go to IDLE.
- Latency: start accepted at edge 0; busy high after edges 0..WIDTH (WIDTH+1 cycles); HI/LO written at edge WIDTH+1; done high for exactly the cycle that follows.
- Back-to-back ops: a new mult/div may start in the done cycle.
- mult/multu: {hi,lo} = full 2*WIDTH product.
- div/divu: lo = quotient, hi = remainder.
- Divide by zero (any sign): hi=A, lo=all ones, normal latency, no flag.
- Signed MIN/-1: lo=MIN, hi=0.
- stall = start & busy & (op is mult/div/mfhi/mflo). Such ops are ignored while busy, and the requester holds them.
- Non-HI/LO ops proceed normally while busy.

Test Plan:
- WIDTH=32, ALUop=10, funct add, A=0x7FFFFFFF, B=1 -> result=0x80000000, overflow=1; same operands with addu -> overflow=0.
- slt A=0xFFFFFFFF, B=1 -> result=1; sltu with the same operands -> result=0, zero=1.
- mult A=0xFFFFFFFD(-3), B=7, start at edge 0 -> busy for 33 cycles, done in cycle after edge 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB; mflo issued while busy -> stall=1.
- divu A=100, B=7 -> lo=14, hi=2. div A=-7, B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div A=5, B=0 -> hi=5, lo=0xFFFFFFFF.
- Pull rst_n low at edge 10 of a mult -> busy=0 and hi=lo=0 immediately, done never pulses; the next mult completes correctly.
- funct 111111 with ALUop=10 -> illegal=1, ALUOperation=1110. With MULDIV_EN=0, funct 011000 -> illegal=1 and start has no effect.

Source files
------------

// File: rtl/alu_control_muldiv.sv
// -----------------------------------------------------------------------------
// alu_control_muldiv
//   ALU control decoder for a MIPS datapath. It decodes ALUop/funct into a
//   4-bit ALU operation class and computes single-cycle results
//   combinationally. It also contains an iterative signed/unsigned
//   multiply/divide unit with HI/LO registers.
//
// Parameters
//   WIDTH      operand/result width (even, >= 4)
//   MULDIV_EN  1: mult/multu/div/divu/mfhi/mflo decoded; 0: flagged illegal
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             instruction valid (qualifies sequential actions only)
//   ALUop, funct      control inputs from the main decoder / instruction
//   A, B              operands rs, rt
//   ALUOperation      decoded operation class
//   result, zero      combinational result and result==0
//   overflow          signed overflow for funct add/sub
//   illegal           unrecognised funct with ALUop=10
//   stall, busy, done handshake towards the control unit
//   hi, lo            HI/LO registers
// -----------------------------------------------------------------------------
module alu_control_muldiv #(
    parameter int WIDTH     = 32,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       ALUop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [3:0]       ALUOperation,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  acc;       // partial product high half / partial remainder
    logic [WIDTH-1:0]  work;      // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0]  opnd;      // multiplicand / divisor magnitude
    logic              is_div;
    logic              neg_q;     // negate product or quotient
    logic              neg_r;     // negate remainder
    logic              div_zero;

    logic [WIDTH-1:0]  sum, diff;
    logic              slt_s, slt_u;
    logic              md_op, hilo_op;

    assign sum   = A + B;
    assign diff  = A - B;
    assign slt_s = $signed(A) < $signed(B);
    assign slt_u = A < B;

    // ---------------- combinational decode ----------------
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        ALUOperation = 4'b1110;
        result       = '0;
        overflow     = 1'b0;
        illegal      = 1'b0;
        md_op        = 1'b0;
        hilo_op      = 1'b0;
        case (ALUop)
            2'b00: begin ALUOperation = 4'b0010; result = sum;  end
            2'b01: begin ALUOperation = 4'b0110; result = diff; end
            2'b11: begin ALUOperation = 4'b0111; result = {{(WIDTH-1){1'b0}}, slt_s}; end
            default: begin
                case (funct)
                    6'b100000, 6'b100001: begin
                        ALUOperation = 4'b0010;
                        result       = sum;
                        overflow     = ~funct[0] & (A[WIDTH-1] == B[WIDTH-1])
                                       & (sum[WIDTH-1] != A[WIDTH-1]);
                    end
                    6'b100010, 6'b100011: begin
                        ALUOperation = 4'b0110;
                        result       = diff;
                        overflow     = ~funct[0] & (A[WIDTH-1] != B[WIDTH-1])
                                       & (diff[WIDTH-1] != A[WIDTH-1]);
                    end
                    6'b100100: begin ALUOperation = 4'b0000; result = A & B;    end
                    6'b100101: begin ALUOperation = 4'b0001; result = A | B;    end
                    6'b100110: begin ALUOperation = 4'b0011; result = A ^ B;    end
                    6'b100111: begin ALUOperation = 4'b1100; result = ~(A | B); end
                    6'b101010: begin ALUOperation = 4'b0111; result = {{(WIDTH-1){1'b0}}, slt_s}; end
                    6'b101011: begin ALUOperation = 4'b1111; result = {{(WIDTH-1){1'b0}}, slt_u}; end
                    6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
                        if (MULDIV_EN) begin
                            ALUOperation = 4'b1000;
                            md_op        = 1'b1;
                            hilo_op      = 1'b1;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    6'b010000, 6'b010010: begin
                        if (MULDIV_EN) begin
                            ALUOperation = 4'b1000;
                            hilo_op      = 1'b1;
                            result       = funct[1] ? lo : hi;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    default: illegal = 1'b1;
                endcase
            end
        endcase
    end

    assign zero  = (result == '0);
    assign stall = start & busy & hilo_op;

    // ---------------- iterative datapath helpers ----------------
    logic              signed_op, sign_a, sign_b;
    logic [WIDTH-1:0]  mag_a, mag_b;
    logic [WIDTH:0]    mul_sum, div_sh, div_sub;
    logic              div_ge;
    logic [2*WIDTH-1:0] prod_mag, prod_fix;
    logic [WIDTH-1:0]  quo_fix, rem_fix;

    // funct[0]=0 selects the signed variants (mult, div).
    assign signed_op = ~funct[0];
    assign sign_a    = signed_op & A[WIDTH-1];
    assign sign_b    = signed_op & B[WIDTH-1];
    assign mag_a     = sign_a ? -A : A;
    assign mag_b     = sign_b ? -B : B;

    assign mul_sum  = {1'b0, acc} + (work[0] ? {1'b0, opnd} : '0);
    assign div_sh   = {acc, work[WIDTH-1]};
    assign div_ge   = div_sh >= {1'b0, opnd};
    assign div_sub  = div_sh - {1'b0, opnd};

    assign prod_mag = {acc, work};
    assign prod_fix = neg_q ? -prod_mag : prod_mag;
    assign quo_fix  = neg_q ? -work : work;
    assign rem_fix  = neg_r ? -acc : acc;

    // ---------------- FSM ----------------
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            work     <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && md_op) begin
                        acc      <= '0;
                        work     <= mag_a;
                        opnd     <= mag_b;
                        is_div   <= funct[1];
                        neg_q    <= sign_a ^ sign_b;
                        neg_r    <= sign_a;
                        div_zero <= (B == '0);
                        cnt      <= CW'(WIDTH);
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (is_div) begin
                        acc  <= div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0];
                        work <= {work[WIDTH-2:0], div_ge};
                    end else begin
                        acc  <= mul_sum[WIDTH:1];
                        work <= {mul_sum[0], work[WIDTH-1:1]};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        // Divide by zero naturally yields remainder |A|, which
                        // re-signs to A; only the quotient needs forcing.
                        hi <= rem_fix;
                        lo <= div_zero ? '1 : quo_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
